// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, column
// drive patterns, the per-frame scan result and small bit-count helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } kp_state_e;

  localparam logic [3:0] COL_PATTERN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } frame_result_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[3]) idx = 2'd3;
    if (v[2]) idx = 2'd2;
    if (v[1]) idx = 2'd1;
    if (v[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan16_fsm.sv
// Press/release debouncer: advances once per scan frame and emits a one-cycle
// accept pulse with the accepted key code, plus a held flag until release.
module key_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       result_valid,
  input  logic [3:0] result_code,
  output logic       accept,
  output logic [3:0] code,
  output logic       held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DS_C = CW'(DEBOUNCE_SCANS);

  kp_state_e     state_r;
  logic [3:0]    cand_r;
  logic [CW-1:0] cnt_r;
  logic          accept_r;
  logic [3:0]    code_r;
  logic          held_r;

  // The same counter tracks matching press frames in DEBOUNCE and release frames in PRESSED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cand_r   <= 4'd0;
      cnt_r    <= '0;
      accept_r <= 1'b0;
      code_r   <= 4'd0;
      held_r   <= 1'b0;
    end else begin
      accept_r <= 1'b0;
      if (frame_tick) begin
        case (state_r)
          ST_IDLE: begin
            if (result_valid) begin
              cand_r <= result_code;
              if (DS_C == CW'(1)) begin
                accept_r <= 1'b1;
                code_r   <= result_code;
                held_r   <= 1'b1;
                cnt_r    <= '0;
                state_r  <= ST_PRESSED;
              end else begin
                cnt_r   <= CW'(1);
                state_r <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (result_valid && (result_code == cand_r)) begin
              if ((cnt_r + CW'(1)) == DS_C) begin
                accept_r <= 1'b1;
                code_r   <= cand_r;
                held_r   <= 1'b1;
                cnt_r    <= '0;
                state_r  <= ST_PRESSED;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else if (result_valid) begin
              cand_r <= result_code;
              cnt_r  <= CW'(1);
            end else begin
              cnt_r   <= '0;
              state_r <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (result_valid) begin
              cnt_r <= '0;
            end else if ((cnt_r + CW'(1)) == DS_C) begin
              cnt_r   <= '0;
              held_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          default: begin
            cnt_r   <= '0;
            held_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign accept = accept_r;
  assign code   = code_r;
  assign held   = held_r;

endmodule

// File: rtl/keypad_scan16.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad, classifies
// each frame, debounces presses and shifts accepted hex digits into number.
module keypad_scan16
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [15:0] number,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  logic [3:0]               row_meta_r;
  logic [3:0]               row_sync_r;
  logic [SCAN_DIV_BITS-1:0] slot_cnt_r;
  logic [1:0]               col_idx_r;
  logic [3:0]               col_r;
  logic [1:0]               acc_cnt_r;   // low bits seen this frame, saturating at 2
  logic [3:0]               acc_code_r;
  logic [15:0]              number_r;

  logic                     slot_end_s;
  logic                     frame_tick_s;
  logic [1:0]               next_idx_s;
  logic [3:0]               lows_s;
  logic [2:0]               samp_cnt_s;
  logic [3:0]               samp_code_s;
  logic [2:0]               sum_s;
  logic [1:0]               acc_cnt_next_s;
  logic [3:0]               acc_code_next_s;
  frame_result_t            result_s;
  logic                     accept_s;
  logic [3:0]               code_s;
  logic                     held_s;

  // Classify the current column sample and fold it into the frame result.
  always_comb begin
    slot_end_s      = &slot_cnt_r;
    frame_tick_s    = slot_end_s && (col_idx_r == 2'd3);
    next_idx_s      = col_idx_r + 2'd1;
    lows_s          = ~row_sync_r;
    samp_cnt_s      = popcount4(lows_s);
    samp_code_s     = {low_index(lows_s), col_idx_r};
    sum_s           = {1'b0, acc_cnt_r} + samp_cnt_s;
    acc_cnt_next_s  = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    acc_code_next_s = acc_code_r;
    if ((acc_cnt_r == 2'd0) && (samp_cnt_s == 3'd1)) begin
      acc_code_next_s = samp_code_s;
    end else begin
      acc_code_next_s = acc_code_r;
    end
    result_s = '{valid: 1'b0, code: 4'd0};
    case (acc_cnt_r)
      2'd0:    result_s = '{valid: (samp_cnt_s == 3'd1), code: samp_code_s};
      2'd1:    result_s = '{valid: (samp_cnt_s == 3'd0), code: acc_code_r};
      default: result_s = '{valid: 1'b0, code: 4'd0};
    endcase
  end

  // Row synchronizer, free-running slot counter and column walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
      slot_cnt_r <= '0;
      col_idx_r  <= 2'd0;
      col_r      <= 4'b1110;
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'd0;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
      slot_cnt_r <= slot_cnt_r + SCAN_DIV_BITS'(1);
      if (slot_end_s) begin
        col_idx_r <= next_idx_s;
        col_r     <= COL_PATTERN[next_idx_s];
        if (frame_tick_s) begin
          acc_cnt_r  <= 2'd0;
          acc_code_r <= 4'd0;
        end else begin
          acc_cnt_r  <= acc_cnt_next_s;
          acc_code_r <= acc_code_next_s;
        end
      end
    end
  end

  key_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick_s),
    .result_valid (result_s.valid),
    .result_code  (result_s.code),
    .accept       (accept_s),
    .code         (code_s),
    .held         (held_s)
  );

  // Entry shift register; shifts on the edge that ends the key_valid pulse, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_r <= 16'h0000;
    end else if (clear) begin
      number_r <= 16'h0000;
    end else if (accept_s) begin
      number_r <= {number_r[11:0], code_s};
    end
  end

  assign col       = col_r;
  assign number    = number_r;
  assign key_code  = code_s;
  assign key_valid = accept_s;
  assign key_held  = held_s;

endmodule

// File: tb/tb_keypad_scan16.sv
// Directed bench for keypad_scan16 with a 4-cycle slot and 2-frame debounce;
// a small keypad model turns a pressed-key mask into row levels.
module tb_keypad_scan16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [15:0] number;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          n_vec;
  int          n_err;
  int          pulse_cnt;

  keypad_scan16 #(
    .SCAN_DIV_BITS (2),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .clear     (clear),
    .col       (col),
    .number    (number),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key 4*r+c pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    logic [15:0] keys;
    int          press;
    int          rel;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic [15:0] exp_num;
    logic        exp_held;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    keys = k;
    repeat (16 * n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge just after col returns to 1110 (frame cycle 0).
  task automatic align();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (col != 4'b0111 && t < 20);
    t = 0;
    do begin @(negedge clk); t++; end while (col != 4'b1110 && t < 8);
    if (col != 4'b1110) chk("align", {28'd0, col}, 32'he);
  endtask

  logic [3:0] exp_col [4];
  int base;
  int wait_cyc;

  initial begin
    n_vec = 0; n_err = 0; pulse_cnt = 0;
    keys = 16'h0000; clear = 1'b0; rst_n = 1'b0;
    exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011; exp_col[3] = 4'b0111;

    vecs[0] = '{16'h0200, 3, 3, 1, 4'h9, 16'h0009, 1'b1};
    vecs[1] = '{16'h0002, 3, 3, 1, 4'h1, 16'h0091, 1'b1};
    vecs[2] = '{16'h0004, 3, 3, 1, 4'h2, 16'h0912, 1'b1};
    vecs[3] = '{16'h0008, 3, 3, 1, 4'h3, 16'h9123, 1'b1};
    vecs[4] = '{16'h0010, 3, 3, 1, 4'h4, 16'h1234, 1'b1};
    vecs[5] = '{16'h0020, 3, 3, 1, 4'h5, 16'h2345, 1'b1};
    vecs[6] = '{16'h8000, 1, 3, 0, 4'h5, 16'h2345, 1'b0};
    vecs[7] = '{16'h0400, 2, 3, 1, 4'hA, 16'h345A, 1'b1};
    vecs[8] = '{16'h0201, 3, 3, 0, 4'hA, 16'h345A, 1'b0};
    vecs[9] = '{16'h0001, 3, 3, 1, 4'h0, 16'h45A0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_outputs", {9'd0, col, number, key_code, key_valid, key_held},
        {9'd0, 4'b1110, 16'h0000, 4'h0, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Idle scan: column walk every 4 cycles, everything else quiet.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("idle_col", {28'd0, col}, {28'd0, exp_col[(k/4)%4]});
      chk("idle_out", {10'd0, number, key_code, key_valid, key_held}, 32'd0);
    end

    foreach (vecs[i]) begin
      align();
      base = pulse_cnt;
      frames(vecs[i].keys, vecs[i].press);
      chk($sformatf("v%0d_held_press", i), {31'd0, key_held}, {31'd0, vecs[i].exp_held});
      frames(16'h0000, vecs[i].rel);
      chk($sformatf("v%0d_pulses", i), pulse_cnt - base, vecs[i].exp_pulses);
      chk($sformatf("v%0d_code", i), {28'd0, key_code}, {28'd0, vecs[i].exp_code});
      chk($sformatf("v%0d_number", i), {16'd0, number}, {16'd0, vecs[i].exp_num});
      chk($sformatf("v%0d_held_rel", i), {31'd0, key_held}, 32'd0);
    end

    // Candidate toggling between two keys every frame never settles.
    align();
    base = pulse_cnt;
    for (int f = 0; f < 4; f++) frames((f % 2 == 0) ? 16'h0008 : 16'h1000, 1);
    frames(16'h0000, 3);
    chk("toggle_pulses", pulse_cnt - base, 0);
    chk("toggle_number", {16'd0, number}, {16'd0, 16'h45A0});

    // Second key while pressed: no new pulse, single ghost frames do not release.
    align();
    base = pulse_cnt;
    frames(16'h0200, 3);
    chk("hold2_pulse", pulse_cnt - base, 1);
    frames(16'h0201, 1);
    chk("hold2_held_a", {31'd0, key_held}, 32'd1);
    frames(16'h0200, 1);
    frames(16'h0201, 1);
    chk("hold2_held_b", {31'd0, key_held}, 32'd1);
    frames(16'h0200, 1);
    chk("hold2_held_c", {31'd0, key_held}, 32'd1);
    frames(16'h0000, 3);
    chk("hold2_pulses", pulse_cnt - base, 1);
    chk("hold2_number", {16'd0, number}, {16'd0, 16'h5A09});
    chk("hold2_code", {28'd0, key_code}, 32'h9);

    // Clear in the accept cycle: clear wins, pulse and code still happen.
    align();
    base = pulse_cnt;
    keys = 16'h0020;
    wait_cyc = 0;
    while (!key_valid && wait_cyc < 80) begin @(negedge clk); wait_cyc++; end
    chk("clr_seen_valid", {31'd0, key_valid}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_number", {16'd0, number}, 32'd0);
    chk("clr_code", {28'd0, key_code}, 32'h5);
    frames(16'h0200, 0);
    frames(16'h0000, 3);
    chk("clr_number_after", {16'd0, number}, 32'd0);
    chk("clr_pulses", pulse_cnt - base, 1);

    // Plain clear leaves key_code and the FSM alone.
    align();
    frames(16'h0040, 3);
    frames(16'h0000, 3);
    chk("k6_number", {16'd0, number}, 32'h0006);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_number", {16'd0, number}, 32'd0);
    chk("clear_code", {28'd0, key_code}, 32'h6);

    // Reset while a key is held, then fresh debounce of the same key.
    align();
    frames(16'h0080, 3);
    chk("pre_rst_held", {31'd0, key_held}, 32'd1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_outputs", {9'd0, col, number, key_code, key_valid, key_held},
        {9'd0, 4'b1110, 16'h0000, 4'h0, 1'b0, 1'b0});
    base = pulse_cnt;
    rst_n = 1'b1;
    wait_cyc = 0;
    while (!key_valid && wait_cyc < 64) begin @(negedge clk); wait_cyc++; end
    chk("rst_reaccept_lat", wait_cyc, 32);
    chk("rst_code", {28'd0, key_code}, 32'h7);
    frames(16'h0000, 3);
    chk("rst_pulses", pulse_cnt - base, 1);
    chk("rst_number", {16'd0, number}, 32'h0007);
    chk("rst_held", {31'd0, key_held}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
